// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer for the RV64 integer datapath: FETCH/DECODE/EXEC/MEM/WB
// with a bounded memory handshake and sticky trap flags for illegal opcodes and bus timeouts.
//
// state  | meaning
// FETCH  | request instruction word at PC, latch IR and bump PC on ready
// DECODE | classify opcode, latch class, trap on illegal opcode
// EXEC   | drive ALU selects; branches resolve and retire here
// MEM    | data request at ALU address (store when class is STORE)
// WB     | register file write from ALU or memory data
// TRAP   | absorbing, left only by reset
module multicycle_control_fsm #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic [2:0]  state,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        alu_src_b,
    output logic [1:0]  alu_op,
    output logic        reg_write,
    output logic        wb_sel,
    output logic        instr_retired,
    output logic        illegal_instr,
    output logic        bus_error
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_BAD
    } iclass_t;

    localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

    state_t     st;
    iclass_t    cls;
    iclass_t    dec_cls;
    logic [7:0] wait_cnt;

    always_comb begin
        case (instruction[6:0])
            7'b0110011: dec_cls = C_R;
            7'b0010011: dec_cls = C_I;
            7'b0000011: dec_cls = C_LOAD;
            7'b0100011: dec_cls = C_STORE;
            7'b1100011: dec_cls = C_BRANCH;
            default:    dec_cls = C_BAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st            <= S_FETCH;
            cls           <= C_R;
            wait_cnt      <= 8'd0;
            illegal_instr <= 1'b0;
            bus_error     <= 1'b0;
        end else begin
            case (st)
                S_FETCH, S_MEM: begin
                    // ready in the final allowed cycle still completes normally
                    if (mem_ready) begin
                        wait_cnt <= 8'd0;
                        if (st == S_FETCH)
                            st <= S_DECODE;
                        else if (cls == C_STORE)
                            st <= S_FETCH;
                        else
                            st <= S_WB;
                    end else if (wait_cnt == WAIT_MAX) begin
                        st        <= S_TRAP;
                        bus_error <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_DECODE: begin
                    cls      <= dec_cls;
                    wait_cnt <= 8'd0;
                    if (dec_cls == C_BAD) begin
                        st            <= S_TRAP;
                        illegal_instr <= 1'b1;
                    end else begin
                        st <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    wait_cnt <= 8'd0;
                    case (cls)
                        C_LOAD, C_STORE: st <= S_MEM;
                        C_BRANCH:        st <= S_FETCH;
                        default:         st <= S_WB;
                    endcase
                end
                S_WB: begin
                    wait_cnt <= 8'd0;
                    st       <= S_FETCH;
                end
                default: st <= S_TRAP;
            endcase
        end
    end

    assign state = st;

    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr_sel  = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = 1'b0;
        alu_src_b     = 1'b0;
        alu_op        = 2'b00;
        reg_write     = 1'b0;
        wb_sel        = 1'b0;
        instr_retired = 1'b0;
        if (rst_n) begin
            case (st)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                S_EXEC: begin
                    case (cls)
                        C_R: alu_op = 2'b10;
                        C_I: begin
                            alu_src_b = 1'b1;
                            alu_op    = 2'b10;
                        end
                        C_LOAD, C_STORE: alu_src_b = 1'b1;
                        C_BRANCH: begin
                            alu_op        = 2'b01;
                            instr_retired = 1'b1;
                            pc_write      = branch_taken;
                            pc_src        = branch_taken;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    mem_req       = 1'b1;
                    mem_addr_sel  = 1'b1;
                    mem_we        = (cls == C_STORE);
                    instr_retired = (cls == C_STORE) && mem_ready;
                end
                S_WB: begin
                    reg_write     = 1'b1;
                    wb_sel        = (cls == C_LOAD);
                    instr_retired = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm (MEM_WAIT_MAX=3): per-cycle state, control and flag checks.
module tb_multicycle_control_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instruction;
    logic        mem_ready;
    logic        branch_taken;
    logic [2:0]  state;
    logic        mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src;
    logic        alu_src_b, reg_write, wb_sel, instr_retired, illegal_instr, bus_error;
    logic [1:0]  alu_op;

    int errors = 0;
    int checks = 0;

    localparam logic [11:0] MREQ = 12'h800, MWE = 12'h400, MAS = 12'h200, IRW = 12'h100,
                            PCW  = 12'h080, PCS = 12'h040, ASB = 12'h020, CMP = 12'h008,
                            FNC  = 12'h010, RW  = 12'h004, WBS = 12'h002, RET = 12'h001;

    localparam logic [31:0] ADDI = 32'h00500093, LW  = 32'h00002083, SW = 32'h00102023,
                            BEQ  = 32'h00000063, ADD = 32'h002081B3, BAD = 32'h0000007F;

    multicycle_control_fsm #(.MEM_WAIT_MAX(3)) dut (
        .clk(clk), .rst_n(rst_n), .instruction(instruction), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .state(state), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr_sel(mem_addr_sel), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write), .wb_sel(wb_sel),
        .instr_retired(instr_retired), .illegal_instr(illegal_instr), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // one cycle: drive inputs, check combinational view of this cycle, advance past the edge
    task automatic cyc(input string tag, input logic [31:0] ins, input logic rdy, input logic bt,
                       input logic [2:0] exp_st, input logic [11:0] exp_o, input logic [1:0] exp_f);
        logic [11:0] o;
        instruction  = ins;
        mem_ready    = rdy;
        branch_taken = bt;
        #1;
        o = {mem_req, mem_we, mem_addr_sel, ir_write, pc_write, pc_src, alu_src_b,
             alu_op, reg_write, wb_sel, instr_retired};
        check({tag, " state"}, 32'(state), 32'(exp_st));
        check({tag, " ctl"}, 32'(o), 32'(exp_o));
        check({tag, " flags"}, 32'({illegal_instr, bus_error}), 32'(exp_f));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        instruction = 32'h0;
        mem_ready = 1'b0;
        branch_taken = 1'b0;
        @(posedge clk);
        #1;
        // held in reset with ready high: nothing may be enabled
        cyc("rst", ADDI, 1'b1, 1'b0, 3'd0, 12'h000, 2'b00);
        rst_n = 1'b1;

        cyc("addi f", ADDI, 1'b1, 1'b0, 3'd0, MREQ | IRW | PCW, 2'b00);
        cyc("addi d", ADDI, 1'b0, 1'b0, 3'd1, 12'h000, 2'b00);
        cyc("addi e", ADDI, 1'b0, 1'b0, 3'd2, ASB | FNC, 2'b00);
        cyc("addi w", ADDI, 1'b0, 1'b0, 3'd4, RW | RET, 2'b00);

        cyc("lw f",  LW, 1'b1, 1'b0, 3'd0, MREQ | IRW | PCW, 2'b00);
        cyc("lw d",  LW, 1'b0, 1'b0, 3'd1, 12'h000, 2'b00);
        cyc("lw e",  LW, 1'b0, 1'b0, 3'd2, ASB, 2'b00);
        cyc("lw m0", LW, 1'b0, 1'b0, 3'd3, MREQ | MAS, 2'b00);
        cyc("lw m1", LW, 1'b0, 1'b0, 3'd3, MREQ | MAS, 2'b00);
        cyc("lw m2", LW, 1'b0, 1'b0, 3'd3, MREQ | MAS, 2'b00);
        cyc("lw m3", LW, 1'b1, 1'b0, 3'd3, MREQ | MAS, 2'b00);
        cyc("lw w",  LW, 1'b0, 1'b0, 3'd4, RW | WBS | RET, 2'b00);

        cyc("sw f",  SW, 1'b1, 1'b0, 3'd0, MREQ | IRW | PCW, 2'b00);
        cyc("sw d",  SW, 1'b0, 1'b0, 3'd1, 12'h000, 2'b00);
        cyc("sw e",  SW, 1'b0, 1'b0, 3'd2, ASB, 2'b00);
        cyc("sw m0", SW, 1'b0, 1'b0, 3'd3, MREQ | MWE | MAS, 2'b00);
        cyc("sw m1", SW, 1'b1, 1'b0, 3'd3, MREQ | MWE | MAS | RET, 2'b00);
        cyc("b2b f", BEQ, 1'b0, 1'b0, 3'd0, MREQ, 2'b00);

        cyc("beqt f", BEQ, 1'b1, 1'b0, 3'd0, MREQ | IRW | PCW, 2'b00);
        cyc("beqt d", BEQ, 1'b1, 1'b0, 3'd1, 12'h000, 2'b00);
        cyc("beqt e", BEQ, 1'b0, 1'b1, 3'd2, CMP | PCW | PCS | RET, 2'b00);
        cyc("beqn f", BEQ, 1'b1, 1'b0, 3'd0, MREQ | IRW | PCW, 2'b00);
        cyc("beqn d", BEQ, 1'b0, 1'b0, 3'd1, 12'h000, 2'b00);
        cyc("beqn e", BEQ, 1'b0, 1'b0, 3'd2, CMP | RET, 2'b00);

        cyc("edge f0", ADD, 1'b0, 1'b0, 3'd0, MREQ, 2'b00);
        cyc("edge f1", ADD, 1'b0, 1'b0, 3'd0, MREQ, 2'b00);
        cyc("edge f2", ADD, 1'b0, 1'b0, 3'd0, MREQ, 2'b00);
        cyc("edge f3", ADD, 1'b1, 1'b0, 3'd0, MREQ | IRW | PCW, 2'b00);
        cyc("add d",   ADD, 1'b0, 1'b0, 3'd1, 12'h000, 2'b00);
        cyc("add e",   ADD, 1'b0, 1'b0, 3'd2, FNC, 2'b00);
        cyc("add w",   ADD, 1'b0, 1'b0, 3'd4, RW | RET, 2'b00);

        cyc("to f0", ADD, 1'b0, 1'b0, 3'd0, MREQ, 2'b00);
        cyc("to f1", ADD, 1'b0, 1'b0, 3'd0, MREQ, 2'b00);
        cyc("to f2", ADD, 1'b0, 1'b0, 3'd0, MREQ, 2'b00);
        cyc("to f3", ADD, 1'b0, 1'b0, 3'd0, MREQ, 2'b00);
        cyc("to trap0", ADD, 1'b1, 1'b0, 3'd7, 12'h000, 2'b01);
        cyc("to trap1", ADD, 1'b1, 1'b1, 3'd7, 12'h000, 2'b01);
        rst_n = 1'b0;
        cyc("to rst", ADD, 1'b1, 1'b0, 3'd7, 12'h000, 2'b01);
        rst_n = 1'b1;

        cyc("ill f", BAD, 1'b1, 1'b0, 3'd0, MREQ | IRW | PCW, 2'b00);
        cyc("ill d", BAD, 1'b0, 1'b0, 3'd1, 12'h000, 2'b00);
        cyc("ill trap0", BAD, 1'b1, 1'b1, 3'd7, 12'h000, 2'b10);
        cyc("ill trap1", ADDI, 1'b1, 1'b0, 3'd7, 12'h000, 2'b10);
        rst_n = 1'b0;
        cyc("ill rst", ADDI, 1'b0, 1'b0, 3'd7, 12'h000, 2'b10);
        rst_n = 1'b1;
        cyc("post f", ADDI, 1'b0, 1'b0, 3'd0, MREQ, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
